// File: rtl/dadda_seq_multiplier.sv
// Iterative multiplier: one CHUNK-bit multiplier slice per cycle through a Dadda tree, N=WIDTH/CHUNK cycles accept-to-valid.
// Result is held in DONE until out_ready_i; retire and accept may share an edge. Optional signed mode: DADDA_MUL_SIGNED_EN.
module dadda_seq_multiplier #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
`ifdef DADDA_MUL_SIGNED_EN
  input  logic                 signed_mode_i,
`endif
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 busy_o
);

  localparam int N    = WIDTH / CHUNK;
  localparam int PW   = WIDTH + CHUNK;
  localparam int PRW  = 2 * WIDTH;
  localparam int MAXH = CHUNK + 2;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Dadda column compression of the WIDTH x CHUNK partial-product matrix, then one carry-propagate add.
  function automatic logic [PW-1:0] chunk_mul(input logic [WIDTH-1:0] x, input logic [CHUNK-1:0] y);
    logic [MAXH-1:0] cur [PW];
    logic [MAXH-1:0] nxt [PW];
    int              ccnt [PW];
    int              ncnt [PW];
    int              dl [16];
    int              ns, h, idx, d;
    logic            s0, s1, s2;
    logic [PW-1:0]   r0, r1;
    for (int c = 0; c < PW; c++) begin
      cur[c] = '0; nxt[c] = '0; ccnt[c] = 0; ncnt[c] = 0;
    end
    for (int k = 0; k < 16; k++) dl[k] = 0;
    for (int j = 0; j < CHUNK; j++) begin
      for (int i = 0; i < WIDTH; i++) begin
        cur[i+j][ccnt[i+j]] = x[i] & y[j];
        ccnt[i+j] = ccnt[i+j] + 1;
      end
    end
    dl[0] = 2;
    ns = 0;
    while (ns < 15 && (dl[ns] * 3) / 2 < CHUNK) begin
      dl[ns+1] = (dl[ns] * 3) / 2;
      ns = ns + 1;
    end
    for (int s = ns; s >= 0; s--) begin
      d = dl[s];
      if (d < CHUNK) begin
        for (int c = 0; c < PW; c++) begin
          nxt[c] = '0; ncnt[c] = 0;
        end
        for (int c = 0; c < PW; c++) begin
          idx = 0;
          h   = ccnt[c] + ncnt[c];
          while (h > d && ccnt[c] - idx >= 2) begin
            s0 = cur[c][idx];
            s1 = cur[c][idx+1];
            if (h - d >= 2 && ccnt[c] - idx >= 3) begin
              s2 = cur[c][idx+2];
              nxt[c][ncnt[c]] = s0 ^ s1 ^ s2;
              ncnt[c] = ncnt[c] + 1;
              if (c + 1 < PW) begin
                nxt[c+1][ncnt[c+1]] = (s0 & s1) | (s0 & s2) | (s1 & s2);
                ncnt[c+1] = ncnt[c+1] + 1;
              end
              idx = idx + 3;
              h   = h - 2;
            end else begin
              nxt[c][ncnt[c]] = s0 ^ s1;
              ncnt[c] = ncnt[c] + 1;
              if (c + 1 < PW) begin
                nxt[c+1][ncnt[c+1]] = s0 & s1;
                ncnt[c+1] = ncnt[c+1] + 1;
              end
              idx = idx + 2;
              h   = h - 1;
            end
          end
          while (idx < ccnt[c]) begin
            nxt[c][ncnt[c]] = cur[c][idx];
            ncnt[c] = ncnt[c] + 1;
            idx = idx + 1;
          end
        end
        for (int c = 0; c < PW; c++) begin
          cur[c] = nxt[c]; ccnt[c] = ncnt[c];
        end
      end
    end
    for (int c = 0; c < PW; c++) begin
      r0[c] = (ccnt[c] > 0) ? cur[c][0] : 1'b0;
      r1[c] = (ccnt[c] > 1) ? cur[c][1] : 1'b0;
    end
    return r0 + r1;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, a_mag, b_mag;
  logic [PRW-1:0]   acc_q, acc_d, prod_q, prod_d, acc_sum, final_sum, pp_ext;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;

`ifdef DADDA_MUL_SIGNED_EN
  always_comb begin
    a_mag = (signed_mode_i && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag = (signed_mode_i && b_i[WIDTH-1]) ? -b_i : b_i;
    neg_d = signed_mode_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
  end
  assign final_sum = neg_q ? -acc_sum : acc_sum;
`else
  assign a_mag     = a_i;
  assign b_mag     = b_i;
  assign neg_d     = 1'b0;
  assign final_sum = acc_sum;
`endif

  assign pp_ext  = PRW'(chunk_mul(a_q, b_q[CHUNK-1:0]));
  assign acc_sum = acc_q + (pp_ext << (CHUNK * int'(cnt_q)));

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    case (state_q)
      IDLE: in_ready_o = 1'b1;
      BUSY: begin
        busy_o = 1'b1;
        acc_d  = acc_sum;
        b_d    = b_q >> CHUNK;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          prod_d  = final_sum;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        in_ready_o  = out_ready_i;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (in_valid_i && in_ready_o) begin
      a_d     = a_mag;
      b_d     = b_mag;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      if (in_valid_i && in_ready_o) neg_q <= neg_d;
    end
  end

  assign product_o = prod_q;

endmodule

// File: tb/tb_dadda_seq_multiplier.sv
// Bench for dadda_seq_multiplier: fixed vectors, handshake corner cases, random operands vs an arithmetic model,
// and a WIDTH=8 sweep over CHUNK in {1,2,8}. Signed vectors are added when DADDA_MUL_SIGNED_EN is defined.
module tb_dadda_seq_multiplier;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy, sm;
  logic [15:0] a, b;
  logic [31:0] product;

  logic [7:0]  a8, b8;
  logic [2:0]  iv8, ir8, ov8, or8, bz8;
  logic [15:0] p8 [3];

  int n_chk, n_fail;

  typedef struct {
    string       name;
    logic [15:0] va;
    logic [15:0] vb;
    logic        vsm;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[$];

  always #5 clk = ~clk;

  dadda_seq_multiplier #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b),
`ifdef DADDA_MUL_SIGNED_EN
    .signed_mode_i(sm),
`endif
    .out_valid_o(out_valid), .out_ready_i(out_ready), .product_o(product), .busy_o(busy)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int CH = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
    dadda_seq_multiplier #(.WIDTH(8), .CHUNK(CH)) u_sw (
      .clk_i(clk), .rst_i(rst), .in_valid_i(iv8[g]), .in_ready_o(ir8[g]),
      .a_i(a8), .b_i(b8),
`ifdef DADDA_MUL_SIGNED_EN
      .signed_mode_i(1'b0),
`endif
      .out_valid_o(ov8[g]), .out_ready_i(or8[g]), .product_o(p8[g]), .busy_o(bz8[g])
    );
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input logic s);
    longint r;
    if (s) r = longint'($signed(x)) * longint'($signed(y));
    else   r = longint'(x) * longint'(y);
    return r[31:0];
  endfunction

  // Called #1 after an edge with in_ready high; lat counts cycles from the accept edge to out_valid.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tsm, input bit retire,
                        output logic [31:0] p, output int lat, output int bcnt);
    in_valid = 1'b1; a = ta; b = tb_v; sm = tsm;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); sm = 1'($urandom);
    lat = -1; bcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) bcnt++;
      if (out_valid) begin lat = i; break; end
      @(posedge clk); #1;
    end
    p = product;
    if (retire) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] p, e;
    logic [15:0] ra, rb;
    logic        rs;
    logic [15:0] e8;
    int          lat, bc;
    int          first [3];
    int          bcnt8 [3];
    int          chw [3];
    chw = '{1, 2, 8};
    n_chk = 0; n_fail = 0;
    clk = 0; rst = 1; in_valid = 0; out_ready = 0; a = 0; b = 0; sm = 0;
    iv8 = 0; or8 = 0; a8 = 0; b8 = 0;

    vt.push_back('{"v1234x5678", 16'h1234, 16'h5678, 1'b0, 32'h06260060});
    vt.push_back('{"vFFFFxFFFF", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001});
    vt.push_back('{"v0000xBEEF", 16'h0000, 16'hBEEF, 1'b0, 32'h00000000});
    vt.push_back('{"v00FFx0101", 16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF});
    vt.push_back('{"v8000x0002", 16'h8000, 16'h0002, 1'b0, 32'h00010000});
`ifdef DADDA_MUL_SIGNED_EN
    vt.push_back('{"sFFFFx0003", 16'hFFFF, 16'h0003, 1'b1, 32'hFFFFFFFD});
    vt.push_back('{"uFFFFx0003", 16'hFFFF, 16'h0003, 1'b0, 32'h0002FFFD});
    vt.push_back('{"s8000x8000", 16'h8000, 16'h8000, 1'b1, 32'h40000000});
    vt.push_back('{"s0007xFFFE", 16'h0007, 16'hFFFE, 1'b1, 32'hFFFFFFF2});
`endif

    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_product", product, 0);
    chk("rst_sweep_in_ready", ir8, 3'b111);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    foreach (vt[i]) begin
      run_op(vt[i].va, vt[i].vb, vt[i].vsm, 1'b1, p, lat, bc);
      chk({vt[i].name, "_product"}, p, vt[i].exp);
      chk({vt[i].name, "_latency"}, lat, 4);
      chk({vt[i].name, "_busy_cycles"}, bc, 4);
      chk({vt[i].name, "_idle_after_retire"}, {out_valid, in_ready}, 2'b01);
    end

    for (int t = 0; t < 20; t++) begin
      ra = 16'($urandom); rb = 16'($urandom);
`ifdef DADDA_MUL_SIGNED_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      e = ref_mul(ra, rb, rs);
      run_op(ra, rb, rs, 1'b1, p, lat, bc);
      chk($sformatf("rand%0d_%h_%h_%0d", t, ra, rb, rs), p, e);
      chk($sformatf("rand%0d_latency", t), lat, 4);
    end

    // Backpressure, then retire and accept on the same edge.
    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, p, lat, bc);
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp%0d_in_ready", i), in_ready, 0);
      chk($sformatf("bp%0d_out_valid", i), out_valid, 1);
      chk($sformatf("bp%0d_product", i), product, 32'h06260060);
      @(posedge clk); #1;
    end
    a = 16'h0002; b = 16'h0003; out_ready = 1'b1;
    #1 chk("bp_in_ready_on_retire", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp_busy_after_swap", busy, 1);
    chk("bp_out_valid_after_swap", out_valid, 0);
    chk("bp_product_held", product, 32'h06260060);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin lat = i; break; end
      @(posedge clk); #1;
    end
    chk("bp_next_latency", lat, 4);
    chk("bp_next_product", product, 32'h00000006);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the second BUSY cycle.
    in_valid = 1'b1; a = 16'h1234; b = 16'h5678; sm = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_product", product, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(16'h00FF, 16'h0101, 1'b0, 1'b1, p, lat, bc);
    chk("post_rst_product", p, 32'h0000FFFF);
    chk("post_rst_latency", lat, 4);

    // WIDTH=8 sweep over CHUNK.
    for (int t = 0; t < 10; t++) begin
      a8 = (t == 0) ? 8'hFF : 8'($urandom);
      b8 = (t == 0) ? 8'hFF : 8'($urandom);
      e8 = 16'(int'(a8) * int'(b8));
      iv8 = 3'b111;
      @(posedge clk); #1;
      iv8 = 3'b000; a8 = 8'($urandom); b8 = 8'($urandom);
      for (int g = 0; g < 3; g++) begin first[g] = -1; bcnt8[g] = 0; end
      for (int i = 0; i < 20; i++) begin
        for (int g = 0; g < 3; g++) begin
          if (bz8[g]) bcnt8[g]++;
          if (ov8[g] && first[g] < 0) first[g] = i;
        end
        if (first[0] >= 0 && first[1] >= 0 && first[2] >= 0) break;
        @(posedge clk); #1;
      end
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("sw%0d_c%0d_product", t, chw[g]), p8[g], e8);
        chk($sformatf("sw%0d_c%0d_latency", t, chw[g]), first[g], 8 / chw[g]);
        chk($sformatf("sw%0d_c%0d_busy_cycles", t, chw[g]), bcnt8[g], 8 / chw[g]);
      end
      or8 = 3'b111;
      @(posedge clk); #1;
      or8 = 3'b000;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
